// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the MEM-stage CPU port and an external agent.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN swaps fixed CPU priority for alternating grants.
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 0,
  parameter int MAX_STARVE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic       OWN_CPU   = 1'b0;
  localparam logic       OWN_EXT   = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, stateNext;
  logic        owner;
  logic        latWe;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [3:0]  wcnt;
  logic        anyReq;
  logic        extWins;
  logic        grant;

  assign anyReq = cpu_req | ext_req;
  assign grant  = (state == IDLE) && anyReq;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Remembers the last port served; starts at EXT so the CPU wins the first tie.
  logic lastGrant;

  assign extWins = ext_req & (~cpu_req | (lastGrant == OWN_CPU));

  always_ff @(posedge clk) begin
    if (reset)
      lastGrant <= OWN_EXT;
    else if (grant)
      lastGrant <= extWins;
  end
`else
  localparam logic [7:0] STARVE_MAX = 8'(MAX_STARVE);
  logic [7:0] starveCnt;

  assign extWins = ext_req & (~cpu_req | (starveCnt == STARVE_MAX));

  // Counts CPU wins that overrode a waiting EXT request.
  always_ff @(posedge clk) begin
    if (reset)
      starveCnt <= 8'd0;
    else if (grant) begin
      if (extWins)
        starveCnt <= 8'd0;
      else if (ext_req && (starveCnt != STARVE_MAX))
        starveCnt <= starveCnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (wcnt == 4'd0) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) && latWe && (wcnt == 4'd0);
    mem_addr  = latAddr;
    mem_wdata = latWdata;
    ext_ack   = (state == RESP) && (owner == OWN_EXT);
    cpu_stall = cpu_req & ~((state == RESP) && (owner == OWN_CPU));
  end

  // Latch the winner's request in IDLE; count down wait states and capture read data in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_CPU;
      latWe     <= 1'b0;
      latAddr   <= 32'd0;
      latWdata  <= 32'd0;
      wcnt      <= 4'd0;
      cpu_rdata <= 32'd0;
      ext_rdata <= 32'd0;
    end else if (grant) begin
      owner    <= extWins;
      latWe    <= extWins ? ext_we    : cpu_we;
      latAddr  <= extWins ? ext_addr  : cpu_addr;
      latWdata <= extWins ? ext_wdata : cpu_wdata;
      wcnt     <= WAIT_INIT;
    end else if (state == ACCESS) begin
      if (wcnt != 4'd0)
        wcnt <= wcnt - 4'd1;
      else if (!latWe) begin
        if (owner == OWN_EXT)
          ext_rdata <= mem_rdata;
        else
          cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with no wait states, one with three.
module tb_dmem_arbiter;

  logic clk;
  logic rst0, rst3;

  logic        cReq0, cWe0, cStall0, eReq0, eWe0, eAck0, mEn0, mWe0;
  logic [31:0] cAddr0, cWdata0, cRdata0, eAddr0, eWdata0, eRdata0, mAddr0, mWdata0, mRdata0;
  logic        cReq3, cWe3, cStall3, eReq3, eWe3, eAck3, mEn3, mWe3;
  logic [31:0] cAddr3, cWdata3, cRdata3, eAddr3, eWdata3, eRdata3, mAddr3, mWdata3, mRdata3;

  logic [31:0] mem0 [0:63];
  logic [31:0] mem3 [0:63];

  logic [31:0] expQ[$];
  logic        expOwner[$];

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.WAIT_CYCLES(0), .MAX_STARVE(4)) dut0 (
    .clk(clk), .reset(rst0),
    .cpu_req(cReq0), .cpu_we(cWe0), .cpu_addr(cAddr0), .cpu_wdata(cWdata0),
    .cpu_rdata(cRdata0), .cpu_stall(cStall0),
    .ext_req(eReq0), .ext_we(eWe0), .ext_addr(eAddr0), .ext_wdata(eWdata0),
    .ext_rdata(eRdata0), .ext_ack(eAck0),
    .mem_en(mEn0), .mem_we(mWe0), .mem_addr(mAddr0), .mem_wdata(mWdata0), .mem_rdata(mRdata0)
  );

  dmem_arbiter #(.WAIT_CYCLES(3), .MAX_STARVE(4)) dut3 (
    .clk(clk), .reset(rst3),
    .cpu_req(cReq3), .cpu_we(cWe3), .cpu_addr(cAddr3), .cpu_wdata(cWdata3),
    .cpu_rdata(cRdata3), .cpu_stall(cStall3),
    .ext_req(eReq3), .ext_we(eWe3), .ext_addr(eAddr3), .ext_wdata(eWdata3),
    .ext_rdata(eRdata3), .ext_ack(eAck3),
    .mem_en(mEn3), .mem_we(mWe3), .mem_addr(mAddr3), .mem_wdata(mWdata3), .mem_rdata(mRdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mRdata0 = mem0[mAddr0[7:2]];
  assign mRdata3 = mem3[mAddr3[7:2]];

  always @(posedge clk) begin
    if (mEn0 && mWe0) mem0[mAddr0[7:2]] <= mWdata0;
    if (mEn3 && mWe3) mem3[mAddr3[7:2]] <= mWdata3;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst0 = 1'b1; rst3 = 1'b1;
    cReq0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mEn0, mWe0, eAck0} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl0 got=%b exp=000", {mEn0, mWe0, eAck0});
    end
    checks++;
    if ({cRdata0, eRdata0, mAddr0, mWdata0} !== 128'd0) begin
      failures++; $display("FAIL reset_data0 got=%h exp=0", {cRdata0, eRdata0, mAddr0, mWdata0});
    end
    checks++;
    if (cStall0 !== 1'b1) begin
      failures++; $display("FAIL reset_stall_req got=%b exp=1", cStall0);
    end
    cReq0 = 1'b0;
    #1;
    checks++;
    if (cStall0 !== 1'b0) begin
      failures++; $display("FAIL reset_stall_idle got=%b exp=0", cStall0);
    end
    checks++;
    if ({mEn3, mWe3, eAck3, cStall3, mAddr3} !== 36'd0) begin
      failures++; $display("FAIL reset_dut3 got=%h exp=0", {mEn3, mWe3, eAck3, cStall3, mAddr3});
    end
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read;
    int n;
    expQ.push_back(32'h0000_1234);
    cAddr0 = 32'h10; cWe0 = 1'b0; cReq0 = 1'b1;
    #1;
    checks++;
    if (cStall0 !== 1'b1) begin
      failures++; $display("FAIL cpu_read_stall_rise got=%b exp=1", cStall0);
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (cStall0 && n < 20);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL cpu_read_latency got=%0d exp=2", n);
    end
    checks++;
    if (cRdata0 !== expQ[0]) begin
      failures++; $display("FAIL cpu_read_data got=%h exp=%h", cRdata0, expQ[0]);
    end
    void'(expQ.pop_front());
    cReq0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ext_write;
    int n, weCnt;
    eAddr0 = 32'h20; eWdata0 = 32'hDEAD_BEEF; eWe0 = 1'b1; eReq0 = 1'b1;
    n = 0; weCnt = 0;
    do begin
      @(negedge clk); n++;
      if (mWe0) begin
        weCnt++;
        checks++;
        if (mAddr0 !== 32'h20) begin
          failures++; $display("FAIL ext_write_addr got=%h exp=00000020", mAddr0);
        end
      end
    end while (!eAck0 && n < 20);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL ext_write_ack_cycle got=%0d exp=2", n);
    end
    checks++;
    if (weCnt !== 1) begin
      failures++; $display("FAIL ext_write_we_pulses got=%0d exp=1", weCnt);
    end
    checks++;
    if (mem0[8] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ext_write_mem got=%h exp=deadbeef", mem0[8]);
    end
    eReq0 = 1'b0; eWe0 = 1'b0;
    @(negedge clk);
    checks++;
    if (eAck0 !== 1'b0) begin
      failures++; $display("FAIL ext_ack_single got=%b exp=0", eAck0);
    end
    // Read the word back through the EXT port.
    expQ.push_back(32'hDEAD_BEEF);
    eReq0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!eAck0 && n < 20);
    checks++;
    if (eRdata0 !== expQ[0] || n !== 2) begin
      failures++; $display("FAIL ext_read got=%h/%0d exp=%h/2", eRdata0, n, expQ[0]);
    end
    void'(expQ.pop_front());
    eReq0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    int n;
    logic got, seen;
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      expOwner.push_back(i % 2 == 1);
`else
      expOwner.push_back(i % 5 == 4);
`endif
    end
    cAddr0 = 32'h10; cWe0 = 1'b0; eAddr0 = 32'h20; eWe0 = 1'b0;
    cReq0 = 1'b1; eReq0 = 1'b1;
    n = 0;
    while (expOwner.size() > 0 && n < 200) begin
      @(negedge clk); n++;
      seen = 1'b0; got = 1'b0;
      if (eAck0) begin seen = 1'b1; got = 1'b1; end
      else if (cReq0 && !cStall0) begin seen = 1'b1; got = 1'b0; end
      if (seen) begin
        checks++;
        if (got !== expOwner[0]) begin
          failures++; $display("FAIL grant_order idx=%0d got=%b exp=%b", 10 - expOwner.size(), got, expOwner[0]);
        end
        void'(expOwner.pop_front());
      end
    end
    checks++;
    if (expOwner.size() !== 0) begin
      failures++; $display("FAIL grant_timeout got=%0d exp=0", expOwner.size());
    end
    expOwner.delete();
    cReq0 = 1'b0; eReq0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wait_write;
    int k, stallCnt, enCnt, weCnt, weAt;
    cAddr3 = 32'h40; cWdata3 = 32'h5A5A_5A5A; cWe3 = 1'b1; cReq3 = 1'b1;
    #1;
    k = 0; stallCnt = cStall3 ? 1 : 0; enCnt = 0; weCnt = 0; weAt = -1;
    do begin
      @(negedge clk); k++;
      if (cStall3) stallCnt++;
      if (mEn3) enCnt++;
      if (mWe3) begin weCnt++; weAt = k; end
    end while (cStall3 && k < 30);
    checks++;
    if (k !== 5 || stallCnt !== 5) begin
      failures++; $display("FAIL wait_stall got=%0d/%0d exp=5/5", k, stallCnt);
    end
    checks++;
    if (enCnt !== 4) begin
      failures++; $display("FAIL wait_mem_en got=%0d exp=4", enCnt);
    end
    checks++;
    if (weCnt !== 1 || weAt !== 4) begin
      failures++; $display("FAIL wait_mem_we got=%0d@%0d exp=1@4", weCnt, weAt);
    end
    checks++;
    if (mem3[16] !== 32'h5A5A_5A5A) begin
      failures++; $display("FAIL wait_mem got=%h exp=5a5a5a5a", mem3[16]);
    end
    cReq3 = 1'b0; cWe3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int n, ackSeen;
    eAddr3 = 32'h60; eWdata3 = 32'hCAFE_F00D; eWe3 = 1'b1; eReq3 = 1'b1;
    @(negedge clk);
    checks++;
    if (mEn3 !== 1'b1) begin
      failures++; $display("FAIL abort_in_access got=%b exp=1", mEn3);
    end
    rst3 = 1'b1; eReq3 = 1'b0;
    @(negedge clk);
    checks++;
    if ({mEn3, mWe3, eAck3, cStall3} !== 4'd0 || {mAddr3, mWdata3, eRdata3} !== 96'd0) begin
      failures++; $display("FAIL abort_outputs got=%b/%h exp=0", {mEn3, mWe3, eAck3, cStall3}, {mAddr3, mWdata3, eRdata3});
    end
    rst3 = 1'b0;
    ackSeen = 0;
    repeat (8) begin
      @(negedge clk);
      if (eAck3 || mWe3) ackSeen++;
    end
    checks++;
    if (ackSeen !== 0 || mem3[24] !== 32'd0) begin
      failures++; $display("FAIL abort_no_commit got=%0d/%h exp=0/00000000", ackSeen, mem3[24]);
    end
    eReq3 = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!eAck3 && n < 30);
    checks++;
    if (n !== 5 || mem3[24] !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL abort_reissue got=%0d/%h exp=5/cafef00d", n, mem3[24]);
    end
    eReq3 = 1'b0; eWe3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] <= 32'd0;
      mem3[i] <= 32'd0;
    end
    mem0[4] <= 32'h0000_1234;
    rst0 = 1'b1; rst3 = 1'b1;
    cReq0 = 1'b0; cWe0 = 1'b0; cAddr0 = 32'd0; cWdata0 = 32'd0;
    eReq0 = 1'b0; eWe0 = 1'b0; eAddr0 = 32'd0; eWdata0 = 32'd0;
    cReq3 = 1'b0; cWe3 = 1'b0; cAddr3 = 32'd0; cWdata3 = 32'd0;
    eReq3 = 1'b0; eWe3 = 1'b0; eAddr3 = 32'd0; eWdata3 = 32'd0;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_arbitration();
    test_wait_write();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
